// File: rtl/dsp_accum_round_sat_out.sv
// rtl/dsp_accum_round_sat_out.sv - accumulator output stage: round-half-up shift, saturate, 2-stage valid/ready pipe
//
// Purpose:
//   Takes the wide signed accumulator result p_i. It adds half an LSB of the
//   output scale and arithmetically shifts right by SHIFT, which rounds half
//   toward +inf. It then clips to a signed OUT_WIDTH word and presents that
//   word on a stallable valid/ready output.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   flush_i     synchronous flush; clears both valids and blocks input
//   p_i         signed accumulator value (IN_WIDTH)
//   p_valid_i   p_i valid
//   p_ready_o   block accepts p_i this cycle
//   y_o         signed rounded/saturated result (OUT_WIDTH)
//   y_valid_o   y_o valid
//   y_ready_i   downstream accepts y_o
//   sat_o       y_o was clipped; qualified by y_valid_o
//   sat_cnt_o   (only with DSP_ACC_SAT_CNT_EN) sticky-at-max count of
//               saturated output transfers
//
// Build option:
//   DSP_ACC_SAT_CNT_EN  adds sat_cnt_o and its counter.

module dsp_accum_round_sat_out #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic [IN_WIDTH-1:0]  p_i,
    input  logic                 p_valid_i,
    output logic                 p_ready_o,
    output logic [OUT_WIDTH-1:0] y_o,
    output logic                 y_valid_o,
    input  logic                 y_ready_i,
    output logic                 sat_o
`ifdef DSP_ACC_SAT_CNT_EN
    ,
    output logic [15:0]          sat_cnt_o
`endif
);

    // Rounding constant: half of the output LSB, or nothing when SHIFT is 0.
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [IN_WIDTH:0] ROUND =
        (SHIFT > 0) ? ({{IN_WIDTH{1'b0}}, 1'b1} << RND_POS) : '0;

    // Output word limits, sign-extended to the stage-1 width for comparison.
    localparam logic signed [IN_WIDTH:0] MAX_POS =
        {{(IN_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] MIN_NEG =
        {{(IN_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    // Stage 1: rounded and shifted value. It carries one extra bit so that
    // adding ROUND to the most positive input cannot wrap negative.
    logic                        v1_q, v1_d;
    logic signed [IN_WIDTH:0]    s1_q, s1_d;

    // Stage 2: the output registers.
    logic                        y_valid_q, y_valid_d;
    logic [OUT_WIDTH-1:0]        y_q, y_d;
    logic                        sat_q, sat_d;

    logic                        en1, en2;
    logic                        p_ready;
    logic                        in_xfer;
    logic signed [IN_WIDTH:0]    r;
    logic [OUT_WIDTH-1:0]        y_clip;
    logic                        sat_clip;

    // Advance enables. Stage 2 may load when it is empty or being drained.
    // Stage 1 may load when it is empty or moving into stage 2.
    always_comb begin
        en2     = !y_valid_q || y_ready_i;
        en1     = !v1_q || en2;
        p_ready = en1 && !flush_i;
        in_xfer = p_valid_i && p_ready;
    end

    // Round-half-up: add half an LSB, then take the floor via arithmetic shift.
    always_comb begin
        r    = $signed({p_i[IN_WIDTH-1], p_i}) + ROUND;
        s1_d = r >>> SHIFT;
    end

    // Saturate the stage-1 value into the output word.
    always_comb begin
        y_clip   = s1_q[OUT_WIDTH-1:0];
        sat_clip = 1'b0;
        if (s1_q > MAX_POS) begin
            y_clip   = MAX_POS[OUT_WIDTH-1:0];
            sat_clip = 1'b1;
        end else if (s1_q < MIN_NEG) begin
            y_clip   = MIN_NEG[OUT_WIDTH-1:0];
            sat_clip = 1'b1;
        end
    end

    // Valid next-state: flush clears the valids and overrides any handshake.
    always_comb begin
        v1_d      = v1_q;
        y_valid_d = y_valid_q;
        if (flush_i) begin
            v1_d      = 1'b0;
            y_valid_d = 1'b0;
        end else begin
            if (en1) v1_d      = in_xfer;
            if (en2) y_valid_d = v1_q;
        end
    end

    // Data next-state. Data are held across a flush so that y_o and sat_o
    // only ever change on a real pipeline advance.
    always_comb begin
        y_d   = y_q;
        sat_d = sat_q;
        if (en2 && !flush_i) begin
            y_d   = y_clip;
            sat_d = sat_clip;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q      <= 1'b0;
            y_valid_q <= 1'b0;
            y_q       <= '0;
            sat_q     <= 1'b0;
        end else begin
            v1_q      <= v1_d;
            y_valid_q <= y_valid_d;
            y_q       <= y_d;
            sat_q     <= sat_d;
        end
    end

    // Stage-1 data has no reset value; it is qualified by v1_q.
    always_ff @(posedge clk) begin
        if (en1 && !flush_i) begin
            s1_q <= s1_d;
        end
    end

    assign p_ready_o = p_ready;
    assign y_o       = y_q;
    assign y_valid_o = y_valid_q;
    assign sat_o     = sat_q;

`ifdef DSP_ACC_SAT_CNT_EN
    // Saturated-transfer counter. It sticks at all-ones, and flush clears it
    // even when a count would happen on the same edge.
    logic [15:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (flush_i) begin
            sat_cnt_d = '0;
        end else if (y_valid_q && y_ready_i && sat_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt_o = sat_cnt_q;
`endif

endmodule

// File: tb/tb_dsp_accum_round_sat_out.sv
// tb/tb_dsp_accum_round_sat_out.sv - self-checking bench for dsp_accum_round_sat_out (64/16/8)

module tb_dsp_accum_round_sat_out;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [63:0] p_i;
    logic        p_valid;
    logic        p_ready_o;
    logic [15:0] y_o;
    logic        y_valid_o;
    logic        y_ready;
    logic        sat_o;
`ifdef DSP_ACC_SAT_CNT_EN
    logic [15:0] sat_cnt_o;
`endif

    dsp_accum_round_sat_out #(
        .IN_WIDTH  (64),
        .OUT_WIDTH (16),
        .SHIFT     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (flush),
        .p_i       (p_i),
        .p_valid_i (p_valid),
        .p_ready_o (p_ready_o),
        .y_o       (y_o),
        .y_valid_o (y_valid_o),
        .y_ready_i (y_ready),
        .sat_o     (sat_o)
`ifdef DSP_ACC_SAT_CNT_EN
        ,
        .sat_cnt_o (sat_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Scoreboard entries are {sat, y}.
    logic [16:0] exp_q[$];
    logic [16:0] dir_q[$];
    int          lat_q[$];
    bit          chk_lat  = 0;
    bit          last_in  = 0;
    bit          last_out = 0;
    int          cnt_m    = 0;

    // Reference: floor((p + 2^7) / 2^8), then clip to the int16 range.
    function automatic logic [16:0] model(input logic [63:0] p);
        logic signed [66:0] x;
        logic signed [66:0] q;
        x = 67'($signed(p)) + 67'sd128;
        if (x >= 0) q = x / 67'sd256;
        else        q = -((-x + 67'sd255) / 67'sd256);
        if (q > 67'sd32767)       return {1'b1, 16'h7FFF};
        else if (q < -67'sd32768) return {1'b1, 16'h8000};
        else                      return {1'b0, q[15:0]};
    endfunction

    // One clock: sample at the falling edge, score the handshakes, then
    // advance to 1 time unit after the next rising edge.
    task automatic step();
        logic [16:0] e;
        int          lat;
        @(negedge clk);
        last_in  = p_valid && p_ready_o;
        last_out = y_valid_o && y_ready && !flush;
        if (flush) begin
            n_vec++;
            if (p_ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL flush_ready got p_ready_o=%0b expected 0", p_ready_o);
            end
        end
        if (last_out) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output got y=%0d sat=%0b expected no output", $signed(y_o), sat_o);
            end else begin
                e = exp_q.pop_front();
                lat = cyc - lat_q.pop_front();
                if ({sat_o, y_o} !== e) begin
                    n_err++;
                    $display("FAIL out_data got y=%0d sat=%0b expected y=%0d sat=%0b",
                             $signed(y_o), sat_o, $signed(e[15:0]), e[16]);
                end
                if (e[16] && cnt_m != 65535) cnt_m++;
                if (chk_lat) begin
                    n_vec++;
                    if (lat != 2) begin
                        n_err++;
                        $display("FAIL latency got %0d cycles expected 2", lat);
                    end
                end
            end
        end
        if (flush) begin
            exp_q.delete();
            lat_q.delete();
            cnt_m = 0;
        end else if (last_in) begin
            if (dir_q.size() > 0) exp_q.push_back(dir_q.pop_front());
            else                  exp_q.push_back(model(p_i));
            lat_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic feed(input logic [63:0] v);
        p_valid = 1'b1;
        p_i     = v;
        for (int k = 0; k < 40; k++) begin
            step();
            if (last_in) begin
                p_valid = 1'b0;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL feed_timeout got no acceptance of %0d expected within 40 cycles", $signed(v));
        p_valid = 1'b0;
    endtask

    task automatic drain();
        p_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0) return;
            step();
        end
        n_vec++;
        n_err++;
        $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
        exp_q.delete();
        lat_q.delete();
    endtask

    task automatic clear_model();
        exp_q.delete();
        lat_q.delete();
        dir_q.delete();
        cnt_m = 0;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        p_valid = 1'b1;
        p_i     = 64'd1000;
        y_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({y_valid_o, y_o, sat_o} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_state got valid=%0b y=%0d sat=%0b expected 0 0 0", y_valid_o, $signed(y_o), sat_o);
        end
        p_valid = 1'b0;
        reset   = 1'b1;
        step();

        // Two samples in flight, then an asynchronous reset mid-cycle.
        y_ready = 1'b0;
        feed(64'd2560);
        feed(64'd5120);
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (y_valid_o !== 1'b0 || y_o !== 16'd0 || sat_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async got valid=%0b y=%0d sat=%0b expected 0 0 0", y_valid_o, $signed(y_o), sat_o);
        end
        clear_model();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        y_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_vec++;
            if (y_valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL reset_residue got y_valid_o=%0b expected 0", y_valid_o);
            end
        end
    endtask

    task automatic test_rounding();
        logic [63:0] v[5];
        v[0] = 64'd10;
        v[1] = 64'd384;
        v[2] = -64'sd384;
        v[3] = 64'd127;
        v[4] = 64'd128;
        dir_q.push_back({1'b0, 16'd0});
        dir_q.push_back({1'b0, 16'd2});
        dir_q.push_back({1'b0, 16'hFFFF});
        dir_q.push_back({1'b0, 16'd0});
        dir_q.push_back({1'b0, 16'd1});
        y_ready = 1'b1;
        chk_lat = 1'b1;
        for (int i = 0; i < 5; i++) feed(v[i]);
        drain();
        chk_lat = 1'b0;
    endtask

    task automatic test_saturation();
        dir_q.push_back({1'b1, 16'h7FFF});
        dir_q.push_back({1'b1, 16'h8000});
        dir_q.push_back({1'b0, 16'h7FFF});
        dir_q.push_back({1'b1, 16'h7FFF});
        y_ready = 1'b1;
        feed(64'd16777216);
        feed(-64'sd16777216);
        feed(64'd8388479);
        feed(64'h7FFF_FFFF_FFFF_FFFF);
        drain();
    endtask

    task automatic test_backpressure();
        dir_q.push_back({1'b0, 16'd1});
        dir_q.push_back({1'b0, 16'd2});
        dir_q.push_back({1'b0, 16'd3});
        y_ready = 1'b0;
        p_valid = 1'b1;
        p_i = 64'd256;
        step();
        p_i = 64'd512;
        step();
        n_vec++;
        if (!last_in) begin
            n_err++;
            $display("FAIL bp_second_accept got accepted=0 expected 1");
        end
        p_i = 64'd768;
        for (int k = 0; k < 2; k++) begin
            step();
            n_vec++;
            if (last_in) begin
                n_err++;
                $display("FAIL bp_full_ready got p_ready_o=1 expected 0");
            end
        end
        y_ready = 1'b1;
        step();
        n_vec++;
        if (!last_in || !last_out) begin
            n_err++;
            $display("FAIL bp_drain_edge got in=%0b out=%0b expected 1 1", last_in, last_out);
        end
        p_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            n_vec++;
            if (!last_out) begin
                n_err++;
                $display("FAIL bp_one_per_cycle got out=0 expected 1");
            end
        end
        drain();
    endtask

    task automatic test_flush();
        y_ready = 1'b0;
        feed(64'd512);
        feed(64'd1024);
        flush   = 1'b1;
        p_valid = 1'b1;
        p_i     = 64'd2048;
        y_ready = 1'b1;
        step();
        n_vec++;
        if (last_in || y_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_clear got accepted=%0b y_valid_o=%0b expected 0 0", last_in, y_valid_o);
        end
        flush = 1'b0;
        dir_q.push_back({1'b0, 16'hFFFF});
        feed(-64'sd256);
        drain();
    endtask

    task automatic test_random();
        logic [31:0]        a;
        logic signed [63:0] b;
        for (int i = 0; i < 400; i++) begin
            p_valid = ($urandom_range(0, 3) != 0);
            y_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 31) == 0);
            a = $urandom;
            case ($urandom_range(0, 3))
                0: p_i = {{32{a[31]}}, a};
                1: begin
                    b = 64'sd8388480 + 64'($urandom_range(0, 511)) - 64'sd256;
                    if (a[0]) b = -b;
                    p_i = b;
                end
                2: p_i = {a, $urandom};
                default: p_i = 64'($urandom_range(0, 32'hFFFFFF)) - 64'd8388608;
            endcase
            step();
        end
        flush   = 1'b0;
        y_ready = 1'b1;
        drain();
    endtask

`ifdef DSP_ACC_SAT_CNT_EN
    task automatic test_sat_cnt();
        y_ready = 1'b1;
        p_valid = 1'b0;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        feed(64'd16777216);
        feed(64'd10);
        feed(-64'sd16777216);
        feed(64'd384);
        feed(64'h7FFF_FFFF_FFFF_FFFF);
        drain();
        n_vec++;
        if (sat_cnt_o !== 16'd3) begin
            n_err++;
            $display("FAIL sat_cnt_three got %0d expected 3", sat_cnt_o);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_vec++;
        if (sat_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL sat_cnt_flush got %0d expected 0", sat_cnt_o);
        end
        p_valid = 1'b1;
        p_i     = 64'd1 << 40;
        for (int k = 0; k < 70000; k++) step();
        drain();
        n_vec++;
        if (sat_cnt_o !== 16'hFFFF || cnt_m != 65535) begin
            n_err++;
            $display("FAIL sat_cnt_sticky got %0d expected 65535", sat_cnt_o);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        flush   = 1'b0;
        p_valid = 1'b0;
        p_i     = '0;
        y_ready = 1'b1;
        test_reset();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_flush();
        test_random();
`ifdef DSP_ACC_SAT_CNT_EN
        test_sat_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
